// File: rtl/adder_pkg.sv
// Shared definitions for the wide adder sequencer: state encoding and
// the slice-index width helper.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Slice index width; at least one bit so CHUNKS=1 still has a legal vector.
   function automatic int calc_idxw(input int chunks);
      int w;
      w = $clog2(chunks);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/simple_carry_adder.sv
// Combinational WIDTH-bit adder with carry in and carry out; the single
// slice datapath shared across all slices of a wide operation.
module simple_carry_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] total_s;

   // Widen every operand by one bit so the carry out lands in the top bit.
   always_comb begin
      total_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   end

   assign sum  = total_s[WIDTH-1:0];
   assign cout = total_s[WIDTH];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: one WIDTH-bit adder is time-shared over CHUNKS
// slices, LSB slice first, with the carry held in a register between slices.
module wide_add_sequencer
   import adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int CHUNKS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH*CHUNKS-1:0]   a,
   input  logic [WIDTH*CHUNKS-1:0]   b,
   input  logic                      cin,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH*CHUNKS-1:0]   sum,
   output logic                      cout,
   output logic                      busy
);

   localparam int OPW  = WIDTH * CHUNKS;
   localparam int IDXW = calc_idxw(CHUNKS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

   state_t            state_r;
   logic [IDXW-1:0]   idx_r;
   logic              carry_r;
   logic [OPW-1:0]    a_reg_r;
   logic [OPW-1:0]    b_reg_r;
   logic [OPW-1:0]    sum_r;
   logic              cout_r;

   logic [WIDTH-1:0]  slice_a_s;
   logic [WIDTH-1:0]  slice_b_s;
   logic [WIDTH-1:0]  slice_sum_s;
   logic              slice_cout_s;

   // Select the current slice of the latched operands for the shared adder.
   always_comb begin
      slice_a_s = a_reg_r[int'(idx_r)*WIDTH +: WIDTH];
      slice_b_s = b_reg_r[int'(idx_r)*WIDTH +: WIDTH];
   end

   simple_carry_adder #(.WIDTH(WIDTH)) u_adder (
      .a    (slice_a_s),
      .b    (slice_b_s),
      .cin  (carry_r),
      .sum  (slice_sum_s),
      .cout (slice_cout_s)
   );

   // Sequencer FSM: accept operands, walk the slices, hold the result until taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         idx_r   <= {IDXW{1'b0}};
         carry_r <= 1'b0;
         a_reg_r <= {OPW{1'b0}};
         b_reg_r <= {OPW{1'b0}};
         sum_r   <= {OPW{1'b0}};
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_reg_r <= a;
                  b_reg_r <= b;
                  carry_r <= cin;
                  idx_r   <= {IDXW{1'b0}};
                  sum_r   <= {OPW{1'b0}};
                  state_r <= RUN;
               end
            end
            RUN: begin
               sum_r[int'(idx_r)*WIDTH +: WIDTH] <= slice_sum_s;
               carry_r <= slice_cout_s;
               if (idx_r == LAST_IDX) begin
                  cout_r  <= slice_cout_s;
                  idx_r   <= {IDXW{1'b0}};
                  state_r <= DONE;
               end else begin
                  idx_r <= idx_r + IDXW'(1);
               end
            end
            DONE: begin
               // Result is held until the consumer takes it; no new accept here.
               if (out_ready) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               idx_r   <= {IDXW{1'b0}};
               carry_r <= 1'b0;
            end
         endcase
      end
   end

   // Handshake and status flags decode the state register only.
   always_comb begin
      in_ready  = (state_r == IDLE);
      out_valid = (state_r == DONE);
      busy      = (state_r != IDLE);
   end

   assign sum  = sum_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: a 4-slice instance and a 1-slice instance.
module tb_wide_add_sequencer;

   logic clk;
   logic rst_n;

   // 4-slice DUT
   logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
   logic [31:0] a, b, sum;

   // 1-slice DUT
   logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
   logic [7:0]  a1, b1, sum1;

   int checks;
   int errors;
   int n;

   wide_add_sequencer #(.WIDTH(8), .CHUNKS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   wide_add_sequencer #(.WIDTH(8), .CHUNKS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one request on the 4-slice DUT (assumes it is idle).
   task automatic accept(input logic [31:0] av, input logic [31:0] bv, input logic cv);
      in_valid = 1'b1;
      a = av;
      b = bv;
      cin = cv;
      tick();
      in_valid = 1'b0;
   endtask

   // Count edges from accept until out_valid, bounded.
   task automatic wait_done(input string tag);
      n = 0;
      while (!out_valid && n < 20) begin
         check({tag, "_busy_run"}, 64'(busy), 64'd1);
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd4);
   endtask

   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [31:0] es, input logic ec);
      accept(av, bv, cv);
      check({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
      wait_done(tag);
      check({tag, "_sum"}, 64'(sum), 64'(es));
      check({tag, "_cout"}, 64'(cout), 64'(ec));
      check({tag, "_busy_done"}, 64'(busy), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = 32'h0; b = 32'h0; cin = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 8'h0; b1 = 8'h0; cin1 = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_in_ready1", 64'(in_ready1), 64'd1);
      rst_n = 1'b1;
      tick();

      run_op("small", 32'h0000_0064, 32'h0000_0032, 1'b0, 32'h0000_0096, 1'b0);
      run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
      run_op("cin", 32'h0000_00C8, 32'h0000_0064, 1'b1, 32'h0000_012D, 1'b0);

      // Backpressure with a competing request held on the inputs.
      accept(32'h0000_00C8, 32'h0000_0064, 1'b1);
      wait_done("bp");
      in_valid = 1'b1;
      a = 32'h1111_1111;
      b = 32'h2222_2222;
      cin = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_sum", 64'(sum), 64'h0000_012D);
         check("bp_cout", 64'(cout), 64'd0);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_sum_kept", 64'(sum), 64'h0000_012D);
      tick();
      in_valid = 1'b0;
      check("bp_new_busy", 64'(busy), 64'd1);
      wait_done("bp_new");
      check("bp_new_sum", 64'(sum), 64'h3333_3333);
      check("bp_new_cout", 64'(cout), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset while the third slice is in flight.
      accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_sum", 64'(sum), 64'd0);
      check("mrst_cout", 64'(cout), 64'd0);
      check("mrst_in_ready", 64'(in_ready), 64'd1);
      run_op("after_rst", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0);

      run_op("max_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);

      // Single-slice instance.
      in_valid1 = 1'b1;
      a1 = 8'hFF;
      b1 = 8'h01;
      cin1 = 1'b0;
      tick();
      in_valid1 = 1'b0;
      check("c1_busy", 64'(busy1), 64'd1);
      check("c1_out_valid_early", 64'(out_valid1), 64'd0);
      tick();
      check("c1_out_valid", 64'(out_valid1), 64'd1);
      check("c1_sum", 64'(sum1), 64'h00);
      check("c1_cout", 64'(cout1), 64'd1);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check("c1_in_ready_after", 64'(in_ready1), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
